serial_write_arbiter: RTL

Shares one serial write buffer (BUF_SIZE-bit shift-out buffer with start / write_count / done handshake) between two requesters: port 0 for forwarded bus traffic, port 1 for injected traffic. It arbitrates round-robin per packet, locks the grant until the packet's last word completes, and sequences start/done with the buffer. A watchdog aborts stalled transfers. It sits between the MITM control logic and the output-side write buffer.

---
 rtl/serial_write_arbiter_if.sv | 37 +++
 rtl/serial_write_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_write_arbiter_if.sv
// Requester and write-buffer signal bundle for serial_write_arbiter.
// The slave modport is the arbiter's view; master is the requesters/buffer side.
interface serial_write_arbiter_if #(
    parameter int BUF_SIZE         = 8,
    parameter int WRITE_COUNT_SIZE = $clog2(BUF_SIZE + 1)
);
    logic                        req0;
    logic                        req1;
    logic [BUF_SIZE-1:0]         data0;
    logic [BUF_SIZE-1:0]         data1;
    logic [WRITE_COUNT_SIZE-1:0] count0;
    logic [WRITE_COUNT_SIZE-1:0] count1;
    logic                        last0;
    logic                        last1;
    logic                        ack0;
    logic                        ack1;
    logic                        ack_err;
    logic                        buf_start;
    logic [BUF_SIZE-1:0]         buf_data;
    logic [WRITE_COUNT_SIZE-1:0] buf_write_count;
    logic                        buf_done;
    logic                        buf_abort;
    logic                        owner;
    logic                        busy;

    modport slave (
        input  req0, req1, data0, data1, count0, count1, last0, last1, buf_done,
        output ack0, ack1, ack_err, buf_start, buf_data, buf_write_count,
               buf_abort, owner, busy
    );

    modport master (
        output req0, req1, data0, data1, count0, count1, last0, last1, buf_done,
        input  ack0, ack1, ack_err, buf_start, buf_data, buf_write_count,
               buf_abort, owner, busy
    );
endinterface

// File: rtl/serial_write_arbiter.sv
// Round-robin, packet-locked arbiter sharing one serial write buffer between
// two requesters, with start/done sequencing and a completion watchdog.
module serial_write_arbiter #(
    parameter int BUF_SIZE         = 8,
    parameter int WRITE_COUNT_SIZE = $clog2(BUF_SIZE + 1),
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    serial_write_arbiter_if.slave  bus
);
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WRITE_COUNT_SIZE-1:0] COUNT_MAX = WRITE_COUNT_SIZE'(BUF_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ARM,
        ST_WAIT_DONE,
        ST_ACK
    } state_t;

    state_t                      state_reg, state_next;
    logic                        owner_reg, owner_next;
    logic                        lock_reg, lock_next;
    logic                        last_reg, last_next;
    logic                        err_reg, err_next;
    logic [BUF_SIZE-1:0]         data_reg, data_next;
    logic [WRITE_COUNT_SIZE-1:0] count_reg, count_next;
    logic [WDOG_W-1:0]           wdog_reg, wdog_next;

    logic [1:0]                  req_vec;
    logic [1:0]                  last_vec;
    logic [BUF_SIZE-1:0]         data_vec [2];
    logic [WRITE_COUNT_SIZE-1:0] count_raw [2];
    logic [WRITE_COUNT_SIZE-1:0] count_clamped [2];
    logic [1:0]                  ack_vec;
    logic                        grant_valid;
    logic                        grant_idx;

    assign req_vec      = {bus.req1, bus.req0};
    assign last_vec     = {bus.last1, bus.last0};
    assign data_vec[0]  = bus.data0;
    assign data_vec[1]  = bus.data1;
    assign count_raw[0] = bus.count0;
    assign count_raw[1] = bus.count1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            // The buffer cannot shift more bits than it holds.
            assign count_clamped[gi] = (count_raw[gi] > COUNT_MAX) ? COUNT_MAX : count_raw[gi];
            assign ack_vec[gi]       = (state_reg == ST_ACK) && (owner_reg == 1'(gi));
        end
    endgenerate

    // While a packet is in flight only its owner may be granted; otherwise
    // a tie goes to whoever did not win last time.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = owner_reg;
        if (lock_reg) begin
            grant_valid = req_vec[owner_reg];
            grant_idx   = owner_reg;
        end else begin
            case (req_vec)
                2'b01:   begin grant_valid = 1'b1; grant_idx = 1'b0;       end
                2'b10:   begin grant_valid = 1'b1; grant_idx = 1'b1;       end
                2'b11:   begin grant_valid = 1'b1; grant_idx = ~owner_reg; end
                default: begin grant_valid = 1'b0; grant_idx = owner_reg;  end
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        lock_next  = lock_reg;
        last_next  = last_reg;
        err_next   = err_reg;
        data_next  = data_reg;
        count_next = count_reg;
        wdog_next  = wdog_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_next = grant_idx;
                    data_next  = data_vec[grant_idx];
                    count_next = count_clamped[grant_idx];
                    last_next  = last_vec[grant_idx];
                    err_next   = 1'b0;
                    wdog_next  = '0;
                    // A zero-length word never touches the buffer.
                    state_next = (count_clamped[grant_idx] == '0) ? ST_ACK : ST_START;
                end
            end
            ST_START: begin
                state_next = ST_ARM;
            end
            ST_ARM: begin
                // Skip one cycle so the buffer's stale done level is not mistaken for completion.
                state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.buf_done) begin
                    state_next = ST_ACK;
                end else if (wdog_reg == WDOG_MAX) begin
                    state_next = ST_ACK;
                    err_next   = 1'b1;
                end else begin
                    wdog_next = wdog_reg + WDOG_W'(1);
                end
            end
            ST_ACK: begin
                lock_next  = !last_reg && !err_reg;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            owner_reg <= 1'b1;
            lock_reg  <= 1'b0;
            last_reg  <= 1'b0;
            err_reg   <= 1'b0;
            data_reg  <= '0;
            count_reg <= '0;
            wdog_reg  <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            lock_reg  <= lock_next;
            last_reg  <= last_next;
            err_reg   <= err_next;
            data_reg  <= data_next;
            count_reg <= count_next;
            wdog_reg  <= wdog_next;
        end
    end

    // Abort and error share the ack cycle so the buffer reset lines up with the rejection.
    assign bus.ack0            = ack_vec[0];
    assign bus.ack1            = ack_vec[1];
    assign bus.ack_err         = (state_reg == ST_ACK) && err_reg;
    assign bus.buf_abort       = (state_reg == ST_ACK) && err_reg;
    assign bus.buf_start       = (state_reg == ST_START);
    assign bus.buf_data        = data_reg;
    assign bus.buf_write_count = count_reg;
    assign bus.owner           = owner_reg;
    assign bus.busy            = (state_reg != ST_IDLE) || lock_reg;

endmodule
